rc4_ksa_shuffle: RTL and testbench

- RC4 key-scheduling (shuffle) state machine.
- Runs after S-array init (S[i]=i) and before the decrypt stage.
- For i = 0..255: j = j + S[i] + key[i mod KEY_BYTES]; then swap S[i] and S[j].
- Drives the shuffle-side request inputs of the working-memory arbiter (data/wren/address/mem_sel) and consumes the arbiter's returned shuffle read data.

---
 rtl/rc4_ksa_shuffle.sv | 155 +++++++++++++++
 tb/tb_rc4_ksa_shuffle.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_shuffle.sv
// RC4 key-scheduling shuffle.
// Walks i over 0..255 and accumulates j = j + S[i] + key[i mod KEY_BYTES].
// On each step it swaps S[i] and S[j] through the working-memory arbiter.
// The S memory has a synchronous read with latency 1. Every read therefore
// uses an address cycle followed by a capture cycle, and one iteration takes
// seven cycles: RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, NEXT.
module rc4_ksa_shuffle #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             q_s,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wren,
  output logic [1:0]             mem_sel,
  output logic                   busy,
  output logic                   done
);

  // Key index counter width; at least one bit even for a single-byte key.
  localparam int K_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    GET_I,
    RD_J,
    GET_J,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } state_t;

  state_t                   state, state_next;
  logic [7:0]               i, j, si, sj;
  logic [K_W-1:0]           k;
  logic [8*KEY_BYTES-1:0]   key_reg;
  logic [7:0]               key_byte;

  // The arbiter routes shuffle requests to the working S memory only.
  assign mem_sel = 2'b01;

  // Select key byte k from the captured key; byte 0 is the most significant byte.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (k == K_W'(n)) key_byte = key_reg[8*(KEY_BYTES-n)-1 -: 8];
    end
  end

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments, so every register
    // samples values from before the edge, whatever order the statements are in.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state sequencing of the seven-cycle iteration and the done handshake.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RD_I;
      RD_I:    state_next = GET_I;
      GET_I:   state_next = RD_J;
      RD_J:    state_next = GET_J;
      GET_J:   state_next = WR_I;
      WR_I:    state_next = WR_J;
      WR_J:    state_next = NEXT;
      NEXT:    state_next = (i == 8'hFF) ? DONE : RD_I;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: index counters, captured S values and the key copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i       <= '0;
      j       <= '0;
      k       <= '0;
      si      <= '0;
      sj      <= '0;
      key_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            key_reg <= secret_key;
            i       <= '0;
            j       <= '0;
            k       <= '0;
          end
        end
        GET_I: begin
          si <= q_s;
          // 8-bit wrap is intended: the sum is taken mod 256.
          j  <= j + q_s + key_byte;
        end
        GET_J: begin
          sj <= q_s;
        end
        NEXT: begin
          // i is not advanced past 255; the exit test ends the run instead.
          if (i != 8'hFF) begin
            i <= i + 8'd1;
            k <= (k == K_LAST) ? '0 : k + K_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory request and status outputs, decoded from the state and the registered indices.
  always_comb begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      IDLE:  busy = 1'b0;
      RD_I:  address = i;
      GET_I: address = i;
      RD_J:  address = j;
      GET_J: address = j;
      WR_I: begin
        // When i == j the two writes land on the same address with the same value.
        address = i;
        data    = sj;
        wren    = 1'b1;
      end
      WR_J: begin
        address = j;
        data    = si;
        wren    = 1'b1;
      end
      NEXT:  ;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_shuffle.sv
// Testbench for rc4_ksa_shuffle.
// Models a synchronous-read S memory and checks the shuffle against a plain
// software RC4 key schedule.
module tb_rc4_ksa_shuffle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  q_s;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic [1:0]  mem_sel;
  logic        busy;
  logic        done;

  rc4_ksa_shuffle #(.KEY_BYTES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .secret_key(secret_key),
    .q_s       (q_s),
    .address   (address),
    .data      (data),
    .wren      (wren),
    .mem_sel   (mem_sel),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // S memory: synchronous read, latency 1; init_mem reloads the identity permutation.
  logic [7:0] mem [256];
  logic       init_mem = 1'b0;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
    end else if (wren) begin
      mem[address] <= data;
    end
    q_s <= mem[address];
  end

  // Write log and protocol monitor, sampled on the falling edge.
  logic [15:0] wr_log [$];
  int          prot_err = 0;
  always @(negedge clk) begin
    if (mem_sel !== 2'b01) prot_err++;
    if (wren === 1'b1) begin
      wr_log.push_back({address, data});
      if (busy !== 1'b1) prot_err++;
    end else if (wren !== 1'b0) begin
      prot_err++;
    end
  end

  // Reference RC4 key schedule computed directly from the algorithm.
  logic [7:0] ref_s [256];
  task automatic ref_ksa(input logic [23:0] key);
    int         jj;
    logic [7:0] t;
    logic [7:0] kb;
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      kb = key[8*(2 - (ii % 3)) +: 8];
      jj = (jj + int'(ref_s[ii]) + int'(kb)) % 256;
      t = ref_s[ii];
      ref_s[ii] = ref_s[jj];
      ref_s[jj] = t;
    end
  endtask

  task automatic load_identity();
    @(negedge clk);
    init_mem = 1'b1;
    @(negedge clk);
    init_mem = 1'b0;
  endtask

  // One complete shuffle: returns the write-log index where this run begins.
  task automatic run_ksa(input logic [23:0] key, input bit hold, input bit perturb, output int base);
    int n;
    int bad;
    load_identity();
    ref_ksa(key);
    base       = wr_log.size();
    secret_key = key;
    start      = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_start", busy, 1);
    if (!hold) start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(posedge clk);
      n++;
      #1;
      if (perturb) begin
        if (n == 50) secret_key = 24'($urandom);
        start = (n < 1700) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    check("done_latency", n, 1792);
    check("busy_in_done", busy, 0);
    check("write_count", wr_log.size() - base, 512);
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_s[a]) bad++;
    check("final_s_mismatches", bad, 0);
    if (hold) begin
      repeat (5) @(posedge clk);
      #1;
      check("done_held_with_start", done, 1);
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    check("done_cleared", done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  typedef struct {
    logic [23:0] key;
    int          iter;
    logic [7:0]  a_i, d_i, a_j, d_j;
  } vec_t;

  vec_t        vecs [7];
  logic [23:0] run_key;
  bit          have_run;
  int          base;
  int          cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected swap writes for the first iterations, worked out by hand.
    vecs[0] = '{24'h000249, 0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{24'h000249, 1, 8'h01, 8'h03, 8'h03, 8'h01};
    vecs[2] = '{24'h000249, 2, 8'h02, 8'h4E, 8'h4E, 8'h02};
    vecs[3] = '{24'hFFFFFF, 0, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[4] = '{24'hFFFFFF, 1, 8'h01, 8'h00, 8'hFF, 8'h01};
    vecs[5] = '{24'hFFFFFF, 2, 8'h02, 8'hFF, 8'h00, 8'h02};
    vecs[6] = '{24'hFFFFFF, 3, 8'h03, 8'hFF, 8'h02, 8'h03};

    reset      = 1'b1;
    start      = 1'b0;
    secret_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_address", address, 0);
    check("reset_data", data, 0);
    check("reset_wren", wren, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mem_sel", mem_sel, 2'b01);

    // Table-driven swap checks; the first key is run with start held through done.
    have_run = 1'b0;
    base     = 0;
    run_key  = '0;
    for (int v = 0; v < 7; v++) begin
      if (!have_run || vecs[v].key !== run_key) begin
        run_ksa(vecs[v].key, !have_run, 1'b0, base);
        run_key  = vecs[v].key;
        have_run = 1'b1;
      end
      check($sformatf("iter%0d_write_i_key%06h", vecs[v].iter, vecs[v].key),
            wr_log[base + 2*vecs[v].iter], {vecs[v].a_i, vecs[v].d_i});
      check($sformatf("iter%0d_write_j_key%06h", vecs[v].iter, vecs[v].key),
            wr_log[base + 2*vecs[v].iter + 1], {vecs[v].a_j, vecs[v].d_j});
    end

    // A second run with the same key must begin with j=0 again.
    run_ksa(24'h000249, 1'b0, 1'b0, base);
    check("rerun_first_write", wr_log[base], 16'h0000);
    check("rerun_iter1_write_j", wr_log[base + 3], 16'h0301);

    // Random keys with start toggling and a mid-run key change, both ignored.
    for (int r = 0; r < 2; r++) run_ksa(24'($urandom), 1'b0, 1'b1, base);

    // Asynchronous reset in the middle of the first WR_I.
    load_identity();
    secret_key = 24'($urandom);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    while (wren !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("reached_wr_i", wren, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_wren", wren, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    check("async_reset_address", address, 0);
    check("async_reset_data", data, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", busy, 0);

    // A complete run must still work after the abort.
    run_ksa(24'($urandom), 1'b0, 1'b0, base);

    check("protocol_errors", prot_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
